mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch requester and the data-memory requester (load/store from memory stage part 1).
- Tracks outstanding transactions in order, so each returning data_ok and rdata goes back to the requester that issued it.
- Returned load data feeds memory stage part 2 unchanged; byte/half extraction and lwl/lwr merging stay in that stage.
- Sits between the CPU core and the bus bridge; it is the only master on the bridge side.

Parameters:
- MAX_OUTSTANDING, 2, depth of the in-order ID queue (1..4); maximum issued requests still awaiting data_ok.
- STARVE_LIMIT, 4, number of consecutive cycles the instruction requester may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request valid.
- inst_addr  in  32  fetch address; size is always 2'b10, wr is always 0.
- inst_addr_ok  out  1  fetch request accepted.
- inst_data_ok  out  1  fetch data returned.
- inst_rdata  out  32  fetch data.
- data_req  in  1  data request valid.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  load data returned, or store completed.
- data_rdata  out  32  load data.
- bus_req  out  1  request to the bridge.
- bus_wr  out  1  write flag to the bridge.
- bus_size  out  2  transfer size to the bridge.
- bus_addr  out  32  address to the bridge.
- bus_wdata  out  32  write data to the bridge.
- bus_addr_ok  in  1  bridge accepted the request.
- bus_data_ok  in  1  bridge returned data or a write response.
- bus_rdata  in  32  bridge read data.
- busy  out  1  ID queue not empty or a request is held.
- resp_err  out  1  sticky flag: bus_data_ok arrived while the ID queue was empty.

Behaviour:
- Reset: state IDLE, ID queue empty, starve counter 0, resp_err 0.
- All outputs are combinational from state, so under reset every bus_*, *_addr_ok and *_data_ok output is 0.
- Owner FSM has three states: IDLE, HOLD_I, HOLD_D.
- In IDLE, when the queue is not full:
  - if data_req=1 and (inst_req=0 or starve counter < STARVE_LIMIT), select the data requester;
  - else if inst_req=1, select the instruction requester.
- The selection drives bus_req and the bus_* fields in the same cycle. Arbitration is zero-latency.
- If bus_addr_ok=0 that cycle, go to HOLD_I or HOLD_D.
  - In a HOLD state, bus_req and all bus fields come from the held requester's live inputs. The requester must keep them stable, per the SRAM-like protocol.
  - Stay in the HOLD state until bus_addr_ok=1, then return to IDLE.
  - No re-arbitration happens while holding.
- Handshake: <owner>_addr_ok = bus_req & bus_addr_ok & (owner matches). The other requester sees addr_ok=0.
- ID queue: push the owner ID (0 = inst, 1 = data) when bus_req & bus_addr_ok. Pop the head when bus_data_ok.
- Queue full means no new bus_req is issued, including in IDLE. A pop and a push in the same cycle are allowed when the queue is not full.
- Routing: inst_data_ok = bus_data_ok & head==0; data_data_ok = bus_data_ok & head==1.
- inst_rdata and data_rdata are both bus_rdata, unregistered.
- Data ordering: returns are strictly in issue order.
- Starve counter:
  - increments, saturating at STARVE_LIMIT, each cycle inst_req=1 in IDLE and the data requester wins;
  - clears when the instruction requester is accepted or inst_req=0.
- bus_data_ok with an empty queue: ignored (no data_ok to either requester) and resp_err is set. resp_err is cleared only by rst.
- Both requests in the same cycle with the queue full: neither is accepted and the starve counter does not change.
- Reset mid-transaction drops held and outstanding IDs. The bridge must be reset in the same cycle.
- Pointer arithmetic: read/write pointers are $clog2(MAX_OUTSTANDING) bits wide, plus a count register of $clog2(MAX_OUTSTANDING+1) bits. Pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Shared defines header: owner ID constants (inst_id = 1'b0, data_id = 1'b1), size encodings, FSM state encodings. Use the existing addr_bus and data_bus widths.
- One sub-module, arb_id_fifo: a parameterized 1-bit-wide in-order FIFO with push, pop, head, full and empty.

Test Plan:
- Single load: data_req, addr=0x1000_0004, size=2; bus_addr_ok in the same cycle; bus_data_ok 3 cycles later with rdata=0xDEAD_BEEF. Expect data_addr_ok=1 in cycle 0, data_data_ok=1 with data_rdata=0xDEAD_BEEF in cycle 3, inst_data_ok=0 throughout.
- Hold: inst_req alone, bus_addr_ok low for 2 cycles. Expect bus_req held with inst_addr; data_req raised during the hold is not granted; after accept, state returns to IDLE and the data request issues the next cycle.
- Starvation: inst_req and data_req both high continuously, all bus_addr_ok/data_ok immediate. Expect 4 data grants, then 1 inst grant, repeating.
- Queue full, MAX_OUTSTANDING=2: issue inst then data with no data_ok. Expect the third request blocked (bus_req=0). Then a single bus_data_ok routes to inst first (inst_data_ok=1), and the next request is accepted in the same cycle as a pop.
- Spurious response: bus_data_ok=1 with the queue empty. Expect resp_err=1 sticky and both *_data_ok=0. rst clears resp_err, and busy returns to 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the fetch/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Owner IDs stored in the in-order return queue
    localparam logic INST_ID = 1'b0;
    localparam logic DATA_ID = 1'b1;

    // Transfer size encodings on the SRAM-like bus
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } owner_state_e;

    // Request payload presented to the bridge
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_id_fifo.sv
// In-order queue of 1-bit owner IDs for issued, not yet returned requests.
module arb_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and data access onto one SRAM-like bus and
// routes returns back to the issuing requester in issue order.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        resp_err
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    owner_state_e        state_q;
    logic [STARVE_W-1:0] starve_q;
    logic                resp_err_q;

    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_head;
    logic     sel_data;
    logic     sel_inst;
    logic     owner_data;
    logic     req_c;
    logic     accept;
    logic     pop;
    bus_cmd_t cmd;

    // Owner selection and bus request; zero-latency in IDLE, sticky while holding
    always_comb begin
        sel_data   = 1'b0;
        sel_inst   = 1'b0;
        owner_data = 1'b0;
        req_c      = 1'b0;
        sel_data = data_req && (!inst_req || (starve_q < STARVE_W'(STARVE_LIMIT)));
        sel_inst = !sel_data && inst_req;
        case (state_q)
            IDLE: begin
                owner_data = sel_data;
                req_c      = sel_data || sel_inst;
            end
            HOLD_I: begin
                owner_data = INST_ID;
                req_c      = inst_req;
            end
            HOLD_D: begin
                owner_data = DATA_ID;
                req_c      = data_req;
            end
            default: begin
                owner_data = 1'b0;
                req_c      = 1'b0;
            end
        endcase
        req_c = req_c && !fifo_full && !rst;
    end

    // Bus payload mux; zero whenever no request is driven
    always_comb begin
        cmd = '0;
        if (req_c) begin
            if (owner_data == DATA_ID) begin
                cmd = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
            end else begin
                cmd = '{wr: 1'b0, size: SIZE_WORD, addr: inst_addr, wdata: '0};
            end
        end
    end

    assign accept = req_c && bus_addr_ok;
    assign pop    = !rst && bus_data_ok && !fifo_empty;

    assign bus_req   = req_c;
    assign bus_wr    = cmd.wr;
    assign bus_size  = cmd.size;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;

    assign inst_addr_ok = accept && (owner_data == INST_ID);
    assign data_addr_ok = accept && (owner_data == DATA_ID);
    assign inst_data_ok = pop && (fifo_head == INST_ID);
    assign data_data_ok = pop && (fifo_head == DATA_ID);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign busy     = !rst && (!fifo_empty || (state_q != IDLE));
    assign resp_err = resp_err_q;

    // Owner FSM, starvation counter and sticky spurious-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_c && !bus_addr_ok) begin
                        state_q <= owner_data ? HOLD_D : HOLD_I;
                    end
                end
                HOLD_I, HOLD_D: begin
                    if (accept) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (!inst_req || inst_addr_ok) begin
                starve_q <= '0;
            end else if ((state_q == IDLE) && sel_data && !fifo_full) begin
                starve_q <= starve_q + STARVE_W'(1);
            end

            if (bus_data_ok && fifo_empty) begin
                resp_err_q <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (owner_data),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with an owner-ID scoreboard.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        resp_err;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy),
        .resp_err     (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = '0;
        data_wdata  = '0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the expected owner and compare routing while bus_data_ok is driven
    task automatic check_return(input string tag, input logic [31:0] rdata);
        logic e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(!e));
            check({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(e));
            check({tag, "_rdata"}, e ? data_rdata : inst_rdata, rdata);
        end
    endtask

    initial begin
        logic [9:0] pat;
        idle_inputs();

        // Reset: requests and responses present but everything gated
        rst         = 1'b1;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        step();
        step();
        #2;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        idle_inputs();
        step();
        rst = 1'b0;
        step();

        // Single load, accepted at once, data three cycles later
        data_req    = 1'b1;
        data_addr   = 32'h1000_0004;
        data_size   = 2'd2;
        bus_addr_ok = 1'b1;
        #2;
        check("ld_bus_req", 32'(bus_req), 32'd1);
        check("ld_bus_addr", bus_addr, 32'h1000_0004);
        check("ld_bus_size", 32'(bus_size), 32'd2);
        check("ld_data_addr_ok", 32'(data_addr_ok), 32'd1);
        check("ld_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        exp_q.push_back(1'b1);
        step();
        idle_inputs();
        for (int c = 1; c < 3; c++) begin
            #2;
            check("ld_wait_data_ok", 32'(data_data_ok), 32'd0);
            check("ld_wait_inst_ok", 32'(inst_data_ok), 32'd0);
            check("ld_wait_busy", 32'(busy), 32'd1);
            step();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hDEAD_BEEF;
        #2;
        check_return("ld", 32'hDEAD_BEEF);
        step();
        idle_inputs();
        #2;
        check("ld_busy_end", 32'(busy), 32'd0);

        // Hold: fetch stalls two cycles, data request waits behind it
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        #2;
        check("hold_bus_req", 32'(bus_req), 32'd1);
        check("hold_bus_addr", bus_addr, 32'hBFC0_0000);
        check("hold_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        step();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_addr  = 32'h0000_2001;
        data_wdata = 32'h0000_00A5;
        #2;
        check("hold_keep_addr", bus_addr, 32'hBFC0_0000);
        check("hold_keep_wr", 32'(bus_wr), 32'd0);
        check("hold_no_data_grant", 32'(data_addr_ok), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        step();
        bus_addr_ok = 1'b1;
        #2;
        check("hold_inst_accept", 32'(inst_addr_ok), 32'd1);
        check("hold_data_blocked", 32'(data_addr_ok), 32'd0);
        exp_q.push_back(1'b0);
        step();
        inst_req = 1'b0;
        #2;
        check("after_hold_data_ok", 32'(data_addr_ok), 32'd1);
        check("after_hold_wr", 32'(bus_wr), 32'd1);
        check("after_hold_size", 32'(bus_size), 32'd0);
        check("after_hold_wdata", bus_wdata, 32'h0000_00A5);
        exp_q.push_back(1'b1);
        step();
        idle_inputs();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1111_2222;
        #2;
        check_return("hold_ret0", 32'h1111_2222);
        step();
        bus_rdata = 32'h3333_4444;
        #2;
        check_return("hold_ret1", 32'h3333_4444);
        step();
        idle_inputs();

        // Starvation: four data grants, then one forced fetch grant
        pat = 10'b0_1111_0_1111;
        for (int i = 0; i < 10; i++) begin
            inst_req    = 1'b1;
            inst_addr   = 32'hBFC0_0100 + 32'(i * 4);
            data_req    = 1'b1;
            data_wr     = 1'b0;
            data_size   = 2'd2;
            data_addr   = 32'h8000_0000 + 32'(i * 4);
            bus_addr_ok = 1'b1;
            bus_data_ok = (i > 0);
            bus_rdata   = 32'hA000_0000 + 32'(i);
            #2;
            check($sformatf("starve_data_grant_%0d", i), 32'(data_addr_ok), 32'(pat[i]));
            check($sformatf("starve_inst_grant_%0d", i), 32'(inst_addr_ok), 32'(!pat[i]));
            check($sformatf("starve_bus_addr_%0d", i), bus_addr, pat[i] ? data_addr : inst_addr);
            if (i > 0) check_return($sformatf("starve_ret_%0d", i), 32'hA000_0000 + 32'(i));
            exp_q.push_back(pat[i]);
            step();
        end
        idle_inputs();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hA000_00FF;
        #2;
        check_return("starve_drain", 32'hA000_00FF);
        step();
        idle_inputs();

        // Queue full: two outstanding block a third, pop then pop+push
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0200;
        bus_addr_ok = 1'b1;
        #2;
        check("full_inst_accept", 32'(inst_addr_ok), 32'd1);
        exp_q.push_back(1'b0);
        step();
        inst_req  = 1'b0;
        data_req  = 1'b1;
        data_addr = 32'h8000_0100;
        data_size = 2'd2;
        #2;
        check("full_data_accept", 32'(data_addr_ok), 32'd1);
        exp_q.push_back(1'b1);
        step();
        inst_req = 1'b1;
        #2;
        check("full_blocked_req", 32'(bus_req), 32'd0);
        check("full_blocked_inst", 32'(inst_addr_ok), 32'd0);
        check("full_blocked_data", 32'(data_addr_ok), 32'd0);
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h5555_0001;
        #2;
        check_return("full_pop_inst", 32'h5555_0001);
        check("full_pop_still_blocked", 32'(bus_req), 32'd0);
        step();
        bus_rdata = 32'h5555_0002;
        #2;
        check_return("full_pop_data", 32'h5555_0002);
        check("full_pop_push_grant", 32'(data_addr_ok), 32'd1);
        exp_q.push_back(1'b1);
        step();
        inst_req = 1'b0;
        data_req = 1'b0;
        bus_rdata = 32'h5555_0003;
        #2;
        check_return("full_last", 32'h5555_0003);
        step();
        idle_inputs();
        #2;
        check("full_busy_end", 32'(busy), 32'd0);

        // Spurious response with an empty queue
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hBAD0_BAD0;
        #2;
        check("spur_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("spur_data_data_ok", 32'(data_data_ok), 32'd0);
        step();
        bus_data_ok = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0300;
        #2;
        check("spur_resp_err", 32'(resp_err), 32'd1);
        step();
        #2;
        check("spur_resp_err_sticky", 32'(resp_err), 32'd1);
        check("spur_busy_hold", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check("spur_rst_bus_req", 32'(bus_req), 32'd0);
        step();
        rst = 1'b0;
        idle_inputs();
        #2;
        check("spur_rst_resp_err", 32'(resp_err), 32'd0);
        check("spur_rst_busy", 32'(busy), 32'd0);
        check("sb_empty_end", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
